// File: rtl/lif_array.sv
// lif_array: time-multiplexed leaky-integrate-and-fire engine for a neuron
// population. Each start_step walks every neuron through SUM, DIFF, SCALE,
// ACC and EMIT using one shared FP32 adder and one shared FP32 multiplier.
// Handshake: spike_valid is a one-cycle strobe with no ready. The consumer
// must take every result. spike_idx, spike_output and voltage_new are
// qualified by spike_valid and hold their values between strobes.
module lif_array #(
    parameter int          NUM_NEURONS = 8,
    parameter int          REF_PERIOD  = 2,
    parameter int          REF_W       = 2,
    parameter logic [31:0] DECAY       = 32'hBD47C3A8,
    parameter logic [31:0] THRESHOLD   = 32'h3F800000,
    localparam int         AW          = $clog2(NUM_NEURONS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_step,
    input  logic          clear_state,
    output logic [AW-1:0] nrn_addr,
    input  logic [31:0]   bias,
    input  logic [31:0]   encoders,
    output logic          busy,
    output logic          spike_valid,
    output logic [AW-1:0] spike_idx,
    output logic          spike_output,
    output logic [31:0]   voltage_new,
    output logic          step_done,
    output logic [2:0]    state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE, S_SUM, S_DIFF, S_SCALE, S_ACC, S_EMIT, S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);

    state_t             state_q, state_d;
    logic [AW-1:0]      n_q;
    logic [31:0]        j_q, d_q, m_q, a_q;
    logic [REF_W-1:0]   rp_q;
    logic [31:0]        v_q   [NUM_NEURONS];
    logic [REF_W-1:0]   ref_q [NUM_NEURONS];
    logic [31:0]        add_a, add_b, add_y, mul_a, mul_b, mul_y;
    logic [31:0]        v_cur, v_keep;
    logic               fire;

    // FP32 add, round-to-nearest-even; subnormals flush to zero and an
    // Inf/NaN operand is returned unchanged.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       x, y;
        logic [7:0]        dexp;
        logic [26:0]       mx, my, sh;
        logic [27:0]       sum;
        logic signed [9:0] e;
        logic [4:0]        lz;
        logic [24:0]       mr;
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'b0};
        if (a[30:23] == 8'h00) return b;
        if (b[30:23] == 8'h00) return a;
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        dexp = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        if (dexp >= 8'd27) begin
            sh = 27'd1;
        end else begin
            sh = my >> dexp;
            sh[0] = sh[0] | (|(my & ((27'd1 << dexp) - 27'd1)));
        end
        e = $signed({2'b00, x[30:23]});
        if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, sh};
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                e = e + 10'sd1;
            end
        end else begin
            sum = {1'b0, mx} - {1'b0, sh};
            if (sum == 28'd0) return 32'h0;
            lz = 5'd0;
            for (int i = 0; i <= 26; i++) if (sum[i]) lz = 5'(26 - i);
            sum = sum << lz;
            e = e - $signed({5'b0, lz});
        end
        if (e <= 10'sd0) return {x[31], 31'b0};
        mr = {1'b0, sum[26:3]} + {24'b0, sum[2] & (sum[1] | sum[0] | sum[3])};
        if (mr[24]) begin mr = mr >> 1; e = e + 10'sd1; end
        if (e >= 10'sd255) return {x[31], 8'hFF, 23'b0};
        return {x[31], e[7:0], mr[22:0]};
    endfunction

    // FP32 multiply, same rounding and special-value handling as fp_add.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s, g, st;
        logic [47:0]        p;
        logic [23:0]        m;
        logic [24:0]        mr;
        logic signed [10:0] e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'b0};
        p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
        if (p[47]) begin
            m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 11'sd1;
        end else begin
            m = p[46:23]; g = p[22]; st = |p[21:0];
        end
        mr = {1'b0, m} + {24'b0, g & (st | m[0])};
        if (mr[24]) begin mr = mr >> 1; e = e + 11'sd1; end
        if (e >= 11'sd255) return {s, 8'hFF, 23'b0};
        if (e <= 11'sd0) return {s, 31'b0};
        return {s, e[7:0], mr[22:0]};
    endfunction

    assign v_cur     = v_q[n_q];
    assign v_keep    = a_q[31] ? 32'h0 : a_q;
    assign fire      = !a_q[31] && (a_q[30:0] >= THRESHOLD[30:0]);
    assign add_y     = fp_add(add_a, add_b);
    assign mul_y     = fp_mul(mul_a, mul_b);
    assign nrn_addr  = n_q;
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

    // Shared arithmetic operand steering, keyed on the current state.
    always_comb begin
        add_a = 32'h0;
        add_b = 32'h0;
        mul_a = 32'h0;
        mul_b = 32'h0;
        case (state_q)
            S_SUM:   begin add_a = bias;  add_b = encoders; end
            S_DIFF:  begin add_a = j_q;   add_b = {~v_cur[31], v_cur[30:0]}; end
            S_SCALE: begin mul_a = d_q;   mul_b = (rp_q == '0) ? DECAY : 32'h0; end
            S_ACC:   begin add_a = v_cur; add_b = {~m_q[31], m_q[30:0]}; end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; clear_state beats a simultaneous start_step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_step && !clear_state) state_d = S_SUM;
            S_SUM:   state_d = S_DIFF;
            S_DIFF:  state_d = S_SCALE;
            S_SCALE: state_d = S_ACC;
            S_ACC:   state_d = S_EMIT;
            S_EMIT:  state_d = (n_q == LAST) ? S_DONE : S_SUM;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath latches, neuron state update and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q          <= '0;
            j_q          <= 32'h0;
            d_q          <= 32'h0;
            m_q          <= 32'h0;
            a_q          <= 32'h0;
            rp_q         <= '0;
            spike_valid  <= 1'b0;
            spike_idx    <= '0;
            spike_output <= 1'b0;
            voltage_new  <= 32'h0;
            step_done    <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i]   <= 32'h0;
                ref_q[i] <= '0;
            end
        end else begin
            spike_valid <= 1'b0;
            step_done   <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (clear_state) begin
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            v_q[i]   <= 32'h0;
                            ref_q[i] <= '0;
                        end
                    end else if (start_step) begin
                        n_q <= '0;
                    end
                end
                S_SUM: begin
                    j_q  <= add_y;
                    rp_q <= (ref_q[n_q] == '0) ? '0 : ref_q[n_q] - 1'b1;
                end
                S_DIFF:  d_q <= add_y;
                S_SCALE: m_q <= mul_y;
                S_ACC:   a_q <= add_y;
                S_EMIT: begin
                    spike_valid  <= 1'b1;
                    spike_idx    <= n_q;
                    spike_output <= fire;
                    if (fire) begin
                        v_q[n_q]    <= 32'h0;
                        ref_q[n_q]  <= REF_W'(REF_PERIOD);
                        voltage_new <= 32'h0;
                    end else begin
                        v_q[n_q]    <= v_keep;
                        ref_q[n_q]  <= rp_q;
                        voltage_new <= v_keep;
                    end
                    if (n_q != LAST) n_q <= n_q + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lif_array.sv
// Bench for lif_array: a 4-neuron instance driven from a vector table plus
// hand-written reset and collision sequences, and a 5-neuron instance with a
// longer refractory period.
module tb_lif_array;
    localparam logic [31:0] ZERO   = 32'h00000000;
    localparam logic [31:0] HALF   = 32'h3F000000;
    localparam logic [31:0] ONE    = 32'h3F800000;
    localparam logic [31:0] TWO    = 32'h40000000;
    localparam logic [31:0] THIRTY = 32'h41F00000;
    localparam logic [31:0] NEG1   = 32'hBF800000;
    localparam logic [31:0] V1     = 32'h3D47C3A8;
    localparam logic [31:0] V2     = 32'h3DC7C3A8;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start4, clear4, busy4, sv4, so4, done4;
    logic [1:0]  addr4, idx4;
    logic [31:0] bias4, enc4, vn4;
    logic [2:0]  st4;
    logic        start5, clear5, busy5, sv5, so5, done5;
    logic [2:0]  addr5, idx5, st5;
    logic [31:0] bias5, enc5, vn5;

    logic [31:0] bias_tab4 [4];
    logic [31:0] enc_tab4  [4];
    logic [31:0] bias_tab5 [5];

    assign bias4 = bias_tab4[addr4];
    assign enc4  = enc_tab4[addr4];
    assign bias5 = bias_tab5[addr5];
    assign enc5  = ZERO;

    lif_array #(.NUM_NEURONS(4)) dut (
        .clk(clk), .rst(rst), .start_step(start4), .clear_state(clear4),
        .nrn_addr(addr4), .bias(bias4), .encoders(enc4), .busy(busy4),
        .spike_valid(sv4), .spike_idx(idx4), .spike_output(so4),
        .voltage_new(vn4), .step_done(done4), .state_dbg(st4)
    );

    lif_array #(.NUM_NEURONS(5), .REF_W(3), .REF_PERIOD(5)) dut5 (
        .clk(clk), .rst(rst), .start_step(start5), .clear_state(clear5),
        .nrn_addr(addr5), .bias(bias5), .encoders(enc5), .busy(busy5),
        .spike_valid(sv5), .spike_idx(idx5), .spike_output(so5),
        .voltage_new(vn5), .step_done(done5), .state_dbg(st5)
    );

    // Scoreboard: observed strobes as {offset, idx, spike, voltage}.
    logic [43:0] exp_q [$];
    logic [43:0] obs_q [$];
    logic [7:0]  done_q [$];

    always @(negedge clk) begin
        if (sv4) obs_q.push_back({8'(cyc - start_cyc), 1'b0, idx4, so4, vn4});
        if (sv5) obs_q.push_back({8'(cyc - start_cyc), idx5, so5, vn5});
        if (done4 || done5) done_q.push_back(8'(cyc - start_cyc));
    end

    typedef struct packed {
        logic [1:0]       pre;   // 0 none, 1 clear first, 2 clear+start together first
        logic             poke;  // pulse start_step while busy
        logic [3:0][31:0] bias;  // element i is neuron i
        logic [3:0][31:0] enc;
        logic [3:0]       spk;
        logic [3:0][31:0] v;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input logic [1:0] pre, input logic poke,
                                input logic [127:0] bias, input logic [127:0] enc,
                                input logic [3:0] spk, input logic [127:0] v);
        vec_t r;
        r.pre = pre; r.poke = poke; r.bias = bias; r.enc = enc; r.spk = spk; r.v = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_clear4();
        @(negedge clk); clear4 = 1'b1;
        @(negedge clk); clear4 = 1'b0;
    endtask

    // Runs one step on the selected instance and scores strobes and step_done.
    task automatic run_step(input int which, input int n, input logic [4:0][31:0] ev,
                            input logic [4:0] es, input bit poke);
        int c;
        obs_q.delete(); done_q.delete(); exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back({8'(5 * (i + 1)), 3'(i), es[i], ev[i]});
        @(negedge clk);
        start_cyc = cyc + 1;
        if (which == 4) start4 = 1'b1; else start5 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; start5 = 1'b0;
        c = 0;
        while (done_q.size() == 0 && c < 150) begin
            start4 = poke && (c >= 2) && (c < 5 * n - 3) && (c % 4 == 2);
            @(negedge clk);
            c++;
        end
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        check("step_done_count", 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0) check("step_done_cycle", 64'(done_q[0]), 64'(5 * n + 1));
        check("strobe_count", 64'(obs_q.size()), 64'(n));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check("strobe{ofs,idx,spk,v}", 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0] es;
        bit saw_busy;
        vecs[0] = mk(2'd1, 1'b0, {ONE, ONE, ONE, ONE}, {ZERO, ZERO, ZERO, ZERO},
                     4'b0000, {V1, V1, V1, V1});
        vecs[1] = mk(2'd1, 1'b0, {NEG1, THIRTY, HALF, ONE}, {ZERO, ZERO, HALF, ZERO},
                     4'b0100, {ZERO, ZERO, V1, V1});
        vecs[2] = mk(2'd0, 1'b1, {NEG1, THIRTY, V1, V1}, {ZERO, ZERO, ZERO, ZERO},
                     4'b0000, {ZERO, ZERO, V1, V1});
        vecs[3] = mk(2'd0, 1'b0, {NEG1, THIRTY, V1, V1}, {ZERO, ZERO, ZERO, ZERO},
                     4'b0100, {ZERO, ZERO, V1, V1});
        vecs[4] = mk(2'd2, 1'b0, {TWO, TWO, TWO, TWO}, {ZERO, ZERO, ZERO, ZERO},
                     4'b0000, {V2, V2, V2, V2});
        vecs[5] = mk(2'd1, 1'b0, {ZERO, HALF, TWO, NEG1}, {ZERO, HALF, ZERO, HALF},
                     4'b0000, {ZERO, V1, V2, ZERO});

        rst = 1'b1; start4 = 1'b0; clear4 = 1'b0; start5 = 1'b0; clear5 = 1'b0;
        for (int i = 0; i < 4; i++) begin bias_tab4[i] = ZERO; enc_tab4[i] = ZERO; end
        for (int i = 0; i < 5; i++) bias_tab5[i] = THIRTY;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values.
        check("rst_busy", 64'(busy4), 64'd0);
        check("rst_spike_valid", 64'(sv4), 64'd0);
        check("rst_spike_output", 64'(so4), 64'd0);
        check("rst_step_done", 64'(done4), 64'd0);
        check("rst_spike_idx", 64'(idx4), 64'd0);
        check("rst_voltage_new", 64'(vn4), 64'd0);
        check("rst_nrn_addr", 64'(addr4), 64'd0);
        check("rst_state", 64'(st4), 64'd0);

        // Table-driven steps on the 4-neuron instance.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) begin
                bias_tab4[i] = vecs[k].bias[i];
                enc_tab4[i]  = vecs[k].enc[i];
            end
            if (vecs[k].pre == 2'd1) pulse_clear4();
            if (vecs[k].pre == 2'd2) begin
                obs_q.delete();
                saw_busy = 1'b0;
                @(negedge clk); clear4 = 1'b1; start4 = 1'b1;
                @(negedge clk); clear4 = 1'b0; start4 = 1'b0;
                repeat (30) begin
                    if (busy4) saw_busy = 1'b1;
                    @(negedge clk);
                end
                check("clear_start_busy", 64'(saw_busy), 64'd0);
                check("clear_start_strobes", 64'(obs_q.size()), 64'd0);
            end
            run_step(4, 4, {ZERO, vecs[k].v}, {1'b0, vecs[k].spk}, vecs[k].poke);
        end

        // Reset during neuron 1 ACC.
        for (int i = 0; i < 4; i++) begin bias_tab4[i] = ONE; enc_tab4[i] = ZERO; end
        pulse_clear4();
        obs_q.delete(); done_q.delete();
        @(negedge clk);
        start_cyc = cyc + 1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        while (cyc < start_cyc + 8) @(negedge clk);
        check("mid_state_acc", 64'(st4), 64'd4);
        check("mid_voltage_before", 64'(vn4), 64'(V1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy4), 64'd0);
        check("mid_rst_spike_valid", 64'(sv4), 64'd0);
        check("mid_rst_spike_output", 64'(so4), 64'd0);
        check("mid_rst_spike_idx", 64'(idx4), 64'd0);
        check("mid_rst_voltage_new", 64'(vn4), 64'd0);
        check("mid_rst_nrn_addr", 64'(addr4), 64'd0);
        check("mid_rst_state", 64'(st4), 64'd0);
        repeat (40) @(negedge clk);
        check("mid_rst_no_done", 64'(done_q.size()), 64'd0);
        check("mid_rst_strobes", 64'(obs_q.size()), 64'd1);
        run_step(4, 4, {ZERO, V1, V1, V1, V1}, 5'b00000, 1'b0);

        // 5-neuron instance, refractory of 5: spike, four silent steps, spike.
        for (int s = 0; s < 6; s++) begin
            es = (s == 0 || s == 5) ? 5'b11111 : 5'b00000;
            run_step(5, 5, {ZERO, ZERO, ZERO, ZERO, ZERO}, es, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
